// File: rtl/seg_add_sub_unit_pkg.sv
// Shared definitions for the segmented add/sub engine: FSM state encoding,
// default geometry and an index-width helper.
package seg_add_sub_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SEG   = 8;

  // Slice index width; a single-slice configuration still needs a 1-bit counter.
  function automatic int unsigned idx_bits(input int unsigned nseg);
    return (nseg > 1) ? $clog2(nseg) : 1;
  endfunction

endpackage

// File: rtl/seg_add_sub_unit_rc_add_sub.sv
// Combinational SEG-bit ripple-carry slice (full-adder chain). The carry into
// the slice MSB is exposed so the top can form signed overflow.
module seg_rc_add_sub #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] A,
  input  logic [SEG-1:0] B,
  input  logic           CI,
  output logic [SEG-1:0] S,
  output logic           CO_MSB_IN,
  output logic           CO
);

  logic c;

  // Ripple the carry through the slice bit by bit.
  always_comb begin
    S         = '0;
    CO_MSB_IN = 1'b0;
    c         = CI;
    for (int unsigned i = 0; i < SEG; i++) begin
      if (i == SEG - 1) CO_MSB_IN = c;
      S[i] = A[i] ^ B[i] ^ c;
      c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
    end
    CO = c;
  end

endmodule

// File: rtl/seg_add_sub_unit.sv
// Multi-cycle two's-complement adder/subtractor: one SEG-bit slice per clock,
// carry held in a register between slices, START/BUSY/DONE handshake and
// CO/V/Z flags.
module seg_add_sub_unit
  import seg_add_sub_unit_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEG   = DEF_SEG
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SnA,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] Y,
  output logic             CO,
  output logic             V,
  output logic             Z
);

  localparam int unsigned NSEG = WIDTH / SEG;
  localparam int unsigned IDXW = idx_bits(NSEG);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSEG - 1);

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bx_q, bx_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             co_q, co_d;
  logic             v_q, v_d;
  logic             z_q, z_d;

  logic [SEG-1:0]   seg_a, seg_b, seg_s;
  logic             seg_msb_ci, seg_co;
  logic             accept;

  // Select the operand slice addressed by the current index.
  always_comb begin
    seg_a = a_q[idx_q*SEG +: SEG];
    seg_b = bx_q[idx_q*SEG +: SEG];
  end

  seg_rc_add_sub #(
    .SEG (SEG)
  ) u_slice (
    .A         (seg_a),
    .B         (seg_b),
    .CI        (carry_q),
    .S         (seg_s),
    .CO_MSB_IN (seg_msb_ci),
    .CO        (seg_co)
  );

  // Next-state, slice write-back and operand capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    bx_d    = bx_q;
    y_d     = y_q;
    co_d    = co_q;
    v_d     = v_q;
    z_d     = z_q;
    accept  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        y_d[idx_q*SEG +: SEG] = seg_s;
        carry_d = seg_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
          co_d    = seg_co;
          v_d     = seg_msb_ci ^ seg_co;
          // Z comes from the fully assembled result so it lands with DONE.
          z_d     = (y_d == '0);
        end
      end
      ST_DONE: begin
        if (START) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Subtract is A + ~B + 1: invert B once at capture and seed the carry.
    if (accept) begin
      a_d     = A;
      bx_d    = B ^ {WIDTH{SnA}};
      carry_d = SnA;
      idx_d   = '0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      bx_q    <= '0;
      y_q     <= '0;
      co_q    <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      bx_q    <= bx_d;
      y_q     <= y_d;
      co_q    <= co_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  // Registered outputs and state-decoded handshake.
  always_comb begin
    BUSY = (state_q == ST_RUN);
    DONE = (state_q == ST_DONE);
    Y    = y_q;
    CO   = co_q;
    V    = v_q;
    Z    = z_q;
  end

endmodule

// File: tb/tb_seg_add_sub_unit.sv
// Directed and random bench for seg_add_sub_unit in three geometries:
// 32/8 (main), 32/32 (single pass) and 64/16.
module tb_seg_add_sub_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        sna = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic [63:0] a64 = '0, b64 = '0;

  logic        busy1, done1, co1, v1, z1;
  logic [31:0] y1;
  logic        busy2, done2, co2, v2, z2;
  logic [31:0] y2;
  logic        busy3, done3, co3, v3, z3;
  logic [63:0] y3;

  int checks = 0;
  int errors = 0;
  int lat1, lat2, lat3, busy1n;

  always #5 clk = ~clk;

  seg_add_sub_unit #(.WIDTH(32), .SEG(8)) dut1 (
    .CLK(clk), .RST(rst), .START(start), .A(a32), .B(b32), .SnA(sna),
    .BUSY(busy1), .DONE(done1), .Y(y1), .CO(co1), .V(v1), .Z(z1));

  seg_add_sub_unit #(.WIDTH(32), .SEG(32)) dut2 (
    .CLK(clk), .RST(rst), .START(start), .A(a32), .B(b32), .SnA(sna),
    .BUSY(busy2), .DONE(done2), .Y(y2), .CO(co2), .V(v2), .Z(z2));

  seg_add_sub_unit #(.WIDTH(64), .SEG(16)) dut3 (
    .CLK(clk), .RST(rst), .START(start), .A(a64), .B(b64), .SnA(sna),
    .BUSY(busy3), .DONE(done3), .Y(y3), .CO(co3), .V(v3), .Z(z3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one START pulse; returns at the first negedge after the accepting edge.
  task automatic launch(input logic [63:0] a, input logic [63:0] b, input logic s, input bit now);
    if (!now) @(negedge clk);
    a32 = a[31:0]; b32 = b[31:0]; a64 = a; b64 = b; sna = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count negedges since accept (n0 = current one) until every DUT has pulsed DONE.
  task automatic wait_done(input int n0);
    lat1 = 0; lat2 = 0; lat3 = 0; busy1n = 0;
    for (int n = n0; n <= n0 + 30; n++) begin
      if (n > n0) @(negedge clk);
      if (busy1) busy1n++;
      if (done1 && lat1 == 0) lat1 = n;
      if (done2 && lat2 == 0) lat2 = n;
      if (done3 && lat3 == 0) lat3 = n;
      if (lat1 != 0 && lat2 != 0 && lat3 != 0) break;
    end
  endtask

  // Whole-word reference: y, co, v, z for a w-bit add/sub.
  task automatic model(input int w, input logic [63:0] a, input logic [63:0] b, input logic s,
                       output logic [63:0] y, output logic co, output logic v, output logic z);
    logic [63:0] mask, am, bx;
    logic [64:0] sum;
    mask = (w == 64) ? '1 : 64'h0000_0000_FFFF_FFFF;
    am   = a & mask;
    bx   = (b ^ {64{s}}) & mask;
    sum  = {1'b0, am} + {1'b0, bx} + {64'd0, s};
    y    = sum[63:0] & mask;
    co   = (w == 64) ? sum[64] : sum[32];
    v    = (am[w-1] == bx[w-1]) && (y[w-1] != am[w-1]);
    z    = (y == '0);
  endtask

  initial begin
    logic [63:0] ra, rb, ey;
    logic        rs, eco, ev, ez;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy1}, 64'd0);
    chk("rst_done", {63'd0, done1}, 64'd0);
    chk("rst_flags", {61'd0, co1, v1, z1}, 64'd0);
    chk("rst_y", {32'd0, y1}, 64'd0);
    rst = 1'b1;

    // 1. Simple add and latency
    launch(64'd5, 64'd3, 1'b0, 1'b0);
    wait_done(1);
    chk("add_lat", 64'(lat1), 64'd5);
    chk("add_busycnt", 64'(busy1n), 64'd4);
    chk("add_y", {32'd0, y1}, 64'd8);
    chk("add_flags", {61'd0, co1, v1, z1}, 64'd0);
    chk("seg32_lat", 64'(lat2), 64'd2);
    chk("seg32_y", {32'd0, y2}, 64'd8);
    chk("w64_y", y3, 64'd8);

    // 2. Carry chain
    launch(64'h0000_00FF, 64'd1, 1'b0, 1'b0);
    wait_done(1);
    chk("carry_y", {32'd0, y1}, 64'h0000_0100);
    chk("carry_flags", {61'd0, co1, v1, z1}, 64'd0);
    launch(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    wait_done(1);
    chk("wrap_y", {32'd0, y1}, 64'd0);
    chk("wrap_flags", {61'd0, co1, v1, z1}, 64'b101);
    chk("w64_wrap_y", y3, 64'd0);
    chk("w64_wrap_co", {63'd0, co3}, 64'd1);
    chk("w64_wrap_lat", 64'(lat3), 64'd5);

    // 3. Subtract and overflow
    launch(64'd3, 64'd5, 1'b1, 1'b0);
    wait_done(1);
    chk("sub_y", {32'd0, y1}, 64'hFFFF_FFFE);
    chk("sub_flags", {61'd0, co1, v1, z1}, 64'b000);
    launch(64'h7FFF_FFFF, 64'd1, 1'b0, 1'b0);
    wait_done(1);
    chk("ovf_add_y", {32'd0, y1}, 64'h8000_0000);
    chk("ovf_add_flags", {61'd0, co1, v1, z1}, 64'b010);
    launch(64'h8000_0000, 64'd1, 1'b1, 1'b0);
    wait_done(1);
    chk("ovf_sub_y", {32'd0, y1}, 64'h7FFF_FFFF);
    chk("ovf_sub_flags", {61'd0, co1, v1, z1}, 64'b110);

    // 4a. START mid-RUN is ignored
    launch(64'h1111_1111, 64'h2222_2222, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    a32 = 32'hDEAD_BEEF; b32 = 32'h0BAD_F00D; a64 = '1; b64 = '1; sna = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(4);
    chk("ignore_lat", 64'(lat1), 64'd5);
    chk("ignore_y", {32'd0, y1}, 64'h3333_3333);
    chk("ignore_w64_y", y3, 64'h3333_3333);

    // 4b. Back-to-back: START in the DONE cycle
    launch(64'd100, 64'd1, 1'b1, 1'b0);
    wait_done(1);
    chk("b2b_first_y", {32'd0, y1}, 64'd99);
    launch(64'd40, 64'd2, 1'b0, 1'b1);
    chk("b2b_busy", {62'd0, busy1, done1}, 64'b10);
    wait_done(1);
    chk("b2b_lat", 64'(lat1), 64'd5);
    chk("b2b_y", {32'd0, y1}, 64'd42);

    // 5. Reset mid-operation (START asserted in the reset cycle too)
    launch(64'hFFFF_FFFF, 64'h8000_0001, 1'b0, 1'b0);
    wait_done(1);
    launch(64'h1234_5678, 64'h1111_1111, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("midrst_state", {62'd0, busy1, done1}, 64'd0);
    chk("midrst_out", {29'd0, y1, co1, v1, z1}, 64'd0);
    chk("midrst_w64", {y3[60:0], co3, v3, z3}, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_idle", {60'd0, busy1, done1, busy3, done3}, 64'd0);
    launch(64'h1234_5678, 64'h1111_1111, 1'b0, 1'b0);
    wait_done(1);
    chk("postrst_lat", 64'(lat1), 64'd5);
    chk("postrst_y", {32'd0, y1}, 64'h2345_6789);

    // 6. Random against whole-word reference
    for (int i = 0; i < 1000; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(1));
      launch(ra, rb, rs, 1'b0);
      wait_done(1);
      model(32, ra, rb, rs, ey, eco, ev, ez);
      chk("rnd32_y", {32'd0, y1}, ey);
      chk("rnd32_flags", {61'd0, co1, v1, z1}, {61'd0, eco, ev, ez});
      chk("rnd32s_y", {32'd0, y2}, ey);
      chk("rnd32s_flags", {61'd0, co2, v2, z2}, {61'd0, eco, ev, ez});
      model(64, ra, rb, rs, ey, eco, ev, ez);
      chk("rnd64_y", y3, ey);
      chk("rnd64_flags", {61'd0, co3, v3, z3}, {61'd0, eco, ev, ez});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
